// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, data width and default bit timing.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } uart_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clock cycles and pulses tick on the last cycle of
// each CLKS_PER_BIT-long period. A synchronous clear restarts the period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    logic [15:0] count;

    assign tick = (count == 16'(CLKS_PER_BIT - 1));

    // Wrapping on tick restarts the period for the next bit without a clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/tx.sv
// UART transmitter: 8N1 frames, LSB first, one-cycle tx_valid after each frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 uout_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 txd,
    output logic                 tx_valid
);

    uart_state_e          state;
    uart_state_e          state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_next;
    logic                 txd_next;
    logic                 tx_valid_next;
    logic                 tick;
    logic                 baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
    logic                 parity_next;
`endif

    // The timer idles at zero so a captured frame starts a full bit period.
    assign baud_clear = !n_rst || (state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_idx_next  = bit_idx;
        txd_next      = txd;
        tx_valid_next = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity;
`endif
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (uout_valid) begin
                    shreg_next = tx_data;
                    state_next = START;
                    txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = even_parity(tx_data);
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    txd_next   = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
                        txd_next     = parity;
`else
                        state_next   = STOP;
                        txd_next     = 1'b1;
`endif
                    end else begin
                        // shreg[0] always holds the bit currently on the line.
                        bit_idx_next = bit_idx + 3'd1;
                        shreg_next   = {1'b0, shreg[DATA_BITS-1:1]};
                        txd_next     = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    txd_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next    = IDLE;
                    txd_next      = 1'b1;
                    tx_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            txd      <= 1'b1;
            tx_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_idx  <= bit_idx_next;
            txd      <= txd_next;
            tx_valid <= tx_valid_next;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_tx.sv
// Bench for tx: directed and randomized frames checked cycle by cycle against
// a frame model built from the serial framing rules.
module tb_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int L = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       uout_valid;
    logic [7:0] tx_data;
    logic       txd;
    logic       tx_valid;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .uout_valid(uout_valid),
        .tx_data   (tx_data),
        .txd       (txd),
        .tx_valid  (tx_valid)
    );

    always #5 clk = ~clk;

    // Expected line level for serial bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == FRAME_BITS - 1) return 1'b1;
        return ((ones % 2) == 1);
    endfunction

    task automatic check(input string tag, input int cyc, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cycle %0d: {txd,tx_valid} observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(tag, k, {txd, tx_valid}, 2'b10);
        end
    endtask

    // Called at a negedge with uout_valid=1 and the DUT idle: capture happens
    // at the next posedge, and every following cycle of the frame is checked.
    task automatic check_frame(input logic [7:0] d, input string tag, input int drop_at,
                               input int change_at, input logic [7:0] new_data);
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            check(tag, k, {txd, tx_valid}, {exp_bit(d, k / CPB), 1'b0});
            if (k == drop_at) uout_valid = 1'b0;
            if (k == change_at) tx_data = new_data;
        end
        @(negedge clk);
        check({tag, "_done"}, L, {txd, tx_valid}, 2'b11);
    endtask

    initial begin
        logic [7:0] b;
        n_rst      = 1'b0;
        uout_valid = 1'b0;
        tx_data    = 8'($urandom);

        // Reset, then 100 idle cycles with no request.
        @(negedge clk);
        check("reset", 0, {txd, tx_valid}, 2'b10);
        n_rst = 1'b1;
        idle_check(100, "reset_idle");

        // Single 0x55 frame, request pulsed for one cycle.
        tx_data    = 8'h55;
        uout_valid = 1'b1;
        check_frame(8'h55, "single", 0, -1, 8'h00);
        idle_check(20, "single_idle");

        // Back-to-back: request held ~3000 ns.
        tx_data    = 8'h55;
        uout_valid = 1'b1;
        check_frame(8'h55, "b2b1", -1, -1, 8'h00);
        check_frame(8'h55, "b2b2", 300 - (L + 1) - 1, -1, 8'h00);
        idle_check(40, "b2b_idle");

        // tx_data changes during data bit 3 must not affect the frame in flight.
        tx_data    = 8'h55;
        uout_valid = 1'b1;
        check_frame(8'h55, "stab1", -1, 4 * CPB + 6, 8'hFF);
        check_frame(8'hFF, "stab2", 0, -1, 8'h00);
        idle_check(10, "stab_idle");

        // Randomized frames with tx_data scrambled mid-frame.
        for (int r = 0; r < 4; r++) begin
            b          = 8'($urandom);
            tx_data    = b;
            uout_valid = 1'b1;
            check_frame(b, "rand", 0, $urandom_range(1, L - 2), 8'($urandom));
            idle_check($urandom_range(1, 5), "rand_gap");
        end

        // Reset during data bit 4.
        tx_data    = 8'h55;
        uout_valid = 1'b1;
        @(negedge clk);
        uout_valid = 1'b0;
        repeat (85) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check("rst_mid", 0, {txd, tx_valid}, 2'b10);
        n_rst = 1'b1;
        idle_check(50, "rst_idle");
        tx_data    = 8'hA3;
        uout_valid = 1'b1;
        check_frame(8'hA3, "post_rst", 0, -1, 8'h00);
        idle_check(10, "post_rst_idle");

        // 0x07 has odd weight, so the parity slot (when present) carries 1.
        tx_data    = 8'h07;
        uout_valid = 1'b1;
        check_frame(8'h07, "par07", 0, -1, 8'h00);
        idle_check(10, "par_idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
